// File: rtl/decode_pkg.sv
// Definitions shared by the fetch window and the decode stages,
// so the instruction window width lives in exactly one place.
package decode_pkg;

    localparam int unsigned WIN_BYTES    = 12;
    localparam int unsigned MAX_INSN_LEN = 12;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/fetch_byte_shifter.sv
// Combinational byte-buffer update: drop consumed bytes from the bottom,
// then merge an incoming stream word at the given byte offset.
module fetch_byte_shifter
    import decode_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 20,
    parameter int unsigned CW        = 5
) (
    input  logic [8*BUF_BYTES-1:0] sbuf_i,
    input  logic [3:0]             shift_i,
    input  logic [CW-1:0]          wr_off_i,
    input  logic [31:0]            wr_data_i,
    input  logic [2:0]             wr_bytes_i,
    output logic [8*BUF_BYTES-1:0] sbuf_o
);

    always_comb begin
        // Zero fill from the top keeps bytes beyond the fill level clean.
        sbuf_o = sbuf_i >> {shift_i, 3'b000};
        for (int unsigned k = 0; k < 4; k++) begin
            if ((k < 32'(wr_bytes_i)) && ((32'(wr_off_i) + k) < BUF_BYTES)) begin
                sbuf_o[8*(32'(wr_off_i) + k) +: 8] = byte_t'(wr_data_i[8*k +: 8]);
            end
        end
    end

endmodule

// File: rtl/fetch_window.sv
// Byte-stream aligner: buffers 32-bit stream words and presents a 12-byte
// instruction window at pc, advancing by the consumer-reported length.
module fetch_window
    import decode_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 20,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_bytes,
    output logic        win_valid,
    output logic [95:0] raw_instr,
    output logic [3:0]  win_count,
    output logic [31:0] pc,
    input  logic        cons_valid,
    input  logic [3:0]  cons_len,
    output logic        err,
    output logic        done
);

    localparam int unsigned CW = $clog2(BUF_BYTES + 1);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] CAP   = CW'(BUF_BYTES - 4);
    localparam logic [CW-1:0] WIN_C = CW'(WIN_BYTES);

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [8*BUF_BYTES-1:0] buf_q, buf_d;
    logic [31:0]            pc_q, pc_d;
    logic                   err_q, err_d;

    logic          eos;
    logic          accept;
    logic          cons_ok;
    logic [2:0]    added;
    logic [2:0]    wr_bytes;
    logic [3:0]    shift;
    logic [CW-1:0] base;

    assign eos       = (state_q != ST_FILL);
    assign in_ready  = !eos && (count_q <= CAP);
    assign win_valid = (count_q >= WIN_C) || (eos && (count_q != '0));
    assign win_count = (count_q >= WIN_C) ? 4'(WIN_BYTES) : 4'(count_q);
    assign pc        = pc_q;
    assign err       = err_q;
    assign done      = (state_q == ST_DONE);

    always_comb begin
        raw_instr = '0;
        for (int unsigned i = 0; i < WIN_BYTES; i++) begin
            if (i < 32'(count_q)) begin
                raw_instr[95-8*i -: 8] = byte_t'(buf_q[8*i +: 8]);
            end
        end
    end

    assign accept  = in_valid && in_ready;
    assign added   = !in_last ? 3'd4 : ((in_bytes > 3'd4) ? 3'd4 : in_bytes);
    assign cons_ok = cons_valid && win_valid && (cons_len != 4'd0) &&
                     (cons_len <= win_count);
    assign shift    = cons_ok ? cons_len : 4'd0;
    assign base     = count_q - CW'(shift);
    assign wr_bytes = accept ? added : 3'd0;

    fetch_byte_shifter #(
        .BUF_BYTES (BUF_BYTES),
        .CW        (CW)
    ) u_shifter (
        .sbuf_i     (buf_q),
        .shift_i    (shift),
        .wr_off_i   (base),
        .wr_data_i  (in_data),
        .wr_bytes_i (wr_bytes),
        .sbuf_o     (buf_d)
    );

    always_comb begin
        count_d = base + CW'(wr_bytes);
        pc_d    = pc_q + 32'(shift);
        err_d   = err_q || (cons_valid && !cons_ok);
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (accept && in_last) begin
                    state_d = (count_d == '0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            count_q <= '0;
            buf_q   <= '0;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_window.sv
// Directed vector bench for fetch_window: one table of per-cycle stimulus
// and expected outputs, plus a second instance exercising pc wrap-around.
module tb_fetch_window;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, cons_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_bytes = '0;
    logic [3:0]  cons_len = '0;
    logic        in_ready, win_valid, err, done;
    logic [95:0] raw_instr;
    logic [3:0]  win_count;
    logic [31:0] pc;

    fetch_window #(.BUF_BYTES(20), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
        .win_valid(win_valid), .raw_instr(raw_instr), .win_count(win_count),
        .pc(pc), .cons_valid(cons_valid), .cons_len(cons_len), .err(err), .done(done)
    );

    logic        w_rst_n = 1'b0, w_in_valid = 1'b0, w_in_last = 1'b0, w_cons_valid = 1'b0;
    logic [31:0] w_in_data = '0;
    logic [2:0]  w_in_bytes = '0;
    logic [3:0]  w_cons_len = '0;
    logic        w_in_ready, w_win_valid, w_err, w_done;
    logic [95:0] w_raw_instr;
    logic [3:0]  w_win_count;
    logic [31:0] w_pc;

    fetch_window #(.BUF_BYTES(20), .RESET_PC(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_last(w_in_last), .in_bytes(w_in_bytes),
        .win_valid(w_win_valid), .raw_instr(w_raw_instr), .win_count(w_win_count),
        .pc(w_pc), .cons_valid(w_cons_valid), .cons_len(w_cons_len), .err(w_err), .done(w_done)
    );

    typedef struct {
        logic        rst_n, iv;
        logic [31:0] data;
        logic        last;
        logic [2:0]  nb;
        logic        cv;
        logic [3:0]  cl;
        logic        rdy, wv;
        logic [3:0]  wc;
        logic [31:0] pc;
        logic        err, done;
        logic [95:0] raw;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic l,
                       input logic [2:0] nb, input logic cv, input logic [3:0] cl,
                       input logic rdy, input logic wv, input logic [3:0] wc,
                       input logic [31:0] p, input logic e, input logic dn,
                       input logic [95:0] raw);
        vec_t v;
        v.rst_n = r; v.iv = iv; v.data = d; v.last = l; v.nb = nb; v.cv = cv; v.cl = cl;
        v.rdy = rdy; v.wv = wv; v.wc = wc; v.pc = p; v.err = e; v.done = dn; v.raw = raw;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [95:0] act,
                       input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        //   rst iv data          last nb cv cl   rdy wv wc  pc            err dn raw
        add(0, 0, 32'h0,          0, 0, 0, 0,   1, 0, 0,  32'h00, 0, 0, 96'h0);
        add(1, 1, 32'h03020100,   0, 0, 0, 0,   1, 0, 4,  32'h00, 0, 0, 96'h00010203_00000000_00000000);
        add(1, 1, 32'h07060504,   0, 0, 0, 0,   1, 0, 8,  32'h00, 0, 0, 96'h00010203_04050607_00000000);
        add(1, 1, 32'h0B0A0908,   0, 0, 0, 0,   1, 1, 12, 32'h00, 0, 0, 96'h00010203_04050607_08090A0B);
        add(1, 1, 32'h0F0E0D0C,   0, 0, 1, 3,   1, 1, 12, 32'h03, 0, 0, 96'h03040506_0708090A_0B0C0D0E);
        add(1, 1, 32'h13121110,   0, 0, 1, 3,   1, 1, 12, 32'h06, 0, 0, 96'h06070809_0A0B0C0D_0E0F1011);
        add(1, 1, 32'h17161514,   0, 0, 1, 3,   1, 1, 12, 32'h09, 0, 0, 96'h090A0B0C_0D0E0F10_11121314);
        add(1, 1, 32'h1B1A1918,   0, 0, 1, 3,   1, 1, 12, 32'h0C, 0, 0, 96'h0C0D0E0F_10111213_14151617);
        add(1, 1, 32'h1F1E1D1C,   0, 0, 0, 0,   0, 1, 12, 32'h0C, 0, 0, 96'h0C0D0E0F_10111213_14151617);
        add(1, 1, 32'h23222120,   0, 0, 1, 12,  1, 0, 8,  32'h18, 0, 0, 96'h18191A1B_1C1D1E1F_00000000);
        add(1, 1, 32'h23222120,   0, 0, 1, 1,   1, 1, 12, 32'h18, 1, 0, 96'h18191A1B_1C1D1E1F_20212223);
        add(1, 0, 32'h0,          0, 0, 1, 13,  1, 1, 12, 32'h18, 1, 0, 96'h18191A1B_1C1D1E1F_20212223);
        add(1, 0, 32'h0,          0, 0, 1, 0,   1, 1, 12, 32'h18, 1, 0, 96'h18191A1B_1C1D1E1F_20212223);
        add(1, 0, 32'h0,          0, 0, 1, 7,   1, 0, 5,  32'h1F, 1, 0, 96'h1F202122_23000000_00000000);
        add(1, 1, 32'hFFFF2524,   1, 2, 0, 0,   0, 1, 7,  32'h1F, 1, 0, 96'h1F202122_23242500_00000000);
        add(1, 0, 32'h0,          0, 0, 1, 3,   0, 1, 4,  32'h22, 1, 0, 96'h22232425_00000000_00000000);
        add(1, 0, 32'h0,          0, 0, 1, 5,   0, 1, 4,  32'h22, 1, 0, 96'h22232425_00000000_00000000);
        add(1, 1, 32'hAAAAAAAA,   0, 0, 1, 4,   0, 0, 0,  32'h26, 1, 1, 96'h0);
        add(1, 0, 32'h0,          0, 0, 1, 1,   0, 0, 0,  32'h26, 1, 1, 96'h0);
        add(0, 0, 32'h0,          0, 0, 0, 0,   1, 0, 0,  32'h00, 0, 0, 96'h0);
        add(1, 1, 32'h33323130,   0, 0, 0, 0,   1, 0, 4,  32'h00, 0, 0, 96'h30313233_00000000_00000000);
        add(1, 1, 32'h37363534,   0, 0, 0, 0,   1, 0, 8,  32'h00, 0, 0, 96'h30313233_34353637_00000000);
        add(1, 1, 32'h99999938,   1, 1, 0, 0,   0, 1, 9,  32'h00, 0, 0, 96'h30313233_34353637_38000000);
        add(1, 0, 32'h0,          0, 0, 1, 13,  0, 1, 9,  32'h00, 1, 0, 96'h30313233_34353637_38000000);
        add(0, 1, 32'h55555555,   0, 0, 1, 2,   1, 0, 0,  32'h00, 0, 0, 96'h0);
        add(1, 1, 32'h43424140,   1, 4, 0, 0,   0, 1, 4,  32'h00, 0, 0, 96'h40414243_00000000_00000000);
        add(1, 0, 32'h0,          0, 0, 1, 4,   0, 0, 0,  32'h04, 0, 1, 96'h0);

        foreach (vq[i]) begin
            rst_n = vq[i].rst_n; in_valid = vq[i].iv; in_data = vq[i].data;
            in_last = vq[i].last; in_bytes = vq[i].nb;
            cons_valid = vq[i].cv; cons_len = vq[i].cl;
            @(posedge clk); #1;
            chk("in_ready",  i, 96'(in_ready),  96'(vq[i].rdy));
            chk("win_valid", i, 96'(win_valid), 96'(vq[i].wv));
            chk("win_count", i, 96'(win_count), 96'(vq[i].wc));
            chk("pc",        i, 96'(pc),        96'(vq[i].pc));
            chk("err",       i, 96'(err),       96'(vq[i].err));
            chk("done",      i, 96'(done),      96'(vq[i].done));
            chk("raw_instr", i, raw_instr,      vq[i].raw);
        end
        in_valid = 1'b0; cons_valid = 1'b0;

        // pc wrap-around on the second instance
        w_rst_n = 1'b0;
        @(posedge clk); #1;
        chk("wrap_reset_pc", 0, 96'(w_pc), 96'(32'hFFFF_FFFE));
        w_rst_n = 1'b1; w_in_valid = 1'b1;
        w_in_data = 32'h03020100; @(posedge clk); #1;
        w_in_data = 32'h07060504; @(posedge clk); #1;
        w_in_data = 32'h0B0A0908; @(posedge clk); #1;
        w_in_valid = 1'b0;
        chk("wrap_win_valid", 1, 96'(w_win_valid), 96'(1'b1));
        w_cons_valid = 1'b1; w_cons_len = 4'd4;
        @(posedge clk); #1;
        w_cons_valid = 1'b0;
        chk("wrap_pc",        2, 96'(w_pc),        96'(32'h0000_0002));
        chk("wrap_win_count", 2, 96'(w_win_count), 96'(4'd8));
        chk("wrap_raw",       2, w_raw_instr,      96'h04050607_08090A0B_00000000);
        chk("wrap_err",       2, 96'(w_err),       96'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
